// File: rtl/normalize_round_if.sv
// Handshake and data bundle between the FP add stage and the normalize/round back end.
interface normalize_round_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
);
    logic                     inValid;
    logic                     inReady;
    logic                     sumSign;
    logic [EXP_W-1:0]         sumExponent;
    logic [MAN_W+1:0]         sumMantissa;
    logic                     guardBit;
    logic                     roundBit;
    logic                     stickyBit;
    logic                     inSpecial;
    logic                     outValid;
    logic                     outReady;
    logic [EXP_W+MAN_W:0]     result;
    logic                     overflow;
    logic                     underflow;
    logic                     inexact;

    modport master (
        output inValid, sumSign, sumExponent, sumMantissa, guardBit, roundBit, stickyBit,
               inSpecial, outReady,
        input  inReady, outValid, result, overflow, underflow, inexact
    );

    modport slave (
        input  inValid, sumSign, sumExponent, sumMantissa, guardBit, roundBit, stickyBit,
               inSpecial, outReady,
        output inReady, outValid, result, overflow, underflow, inexact
    );
endinterface

// File: rtl/normalize_round.sv
// FP adder back end: normalize, round-to-nearest-even and pack one IEEE-754 result at a time.
// Define NORM_FAST_SHIFT_EN for a single-cycle left normalize instead of one bit per cycle.
module normalize_round #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input logic              clock,
    input logic              resetN,
    normalize_round_if.slave bus
);
    localparam int unsigned MW    = MAN_W + 2;
    localparam int unsigned EW    = EXP_W + 1;
    localparam int unsigned RES_W = 1 + EXP_W + MAN_W;
    localparam logic [EW-1:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};

    typedef enum logic [2:0] {StIdle, StCheck, StShift, StRound, StDone} state_t;

    state_t             r_state, w_state_d;
    logic               r_sign, w_sign_d;
    logic               r_special, w_special_d;
    logic [EW-1:0]      r_exp, w_exp_d;
    logic [MW-1:0]      r_man, w_man_d;
    logic               r_g, w_g_d;
    logic               r_r, w_r_d;
    logic               r_s, w_s_d;
    logic [RES_W-1:0]   r_result, w_result_d;
    logic               r_ovf, w_ovf_d;
    logic               r_unf, w_unf_d;
    logic               r_inx, w_inx_d;

    logic               w_inc;
    logic [MW-1:0]      w_sum;
    logic [MW-1:0]      w_rnd_man;
    logic [EW-1:0]      w_rnd_exp;

`ifdef NORM_FAST_SHIFT_EN
    logic [MAN_W+2:0]   w_vec;
    logic [MAN_W+2:0]   w_shl;
    logic [EW-1:0]      w_lzc;
    logic [EW-1:0]      w_lim;
    logic [EW-1:0]      w_amt;
`endif

    // Carry is always clear on entry to ROUND, so the increment cannot wrap w_sum.
    assign w_inc     = r_g & (r_r | r_s | r_man[0]);
    assign w_sum     = r_man + MW'(w_inc);
    assign w_rnd_man = w_sum[MW-1] ? {2'b01, {MAN_W{1'b0}}} : w_sum;
    assign w_rnd_exp = w_sum[MW-1] ? r_exp + EW'(1) : r_exp;

`ifdef NORM_FAST_SHIFT_EN
    // Leading zeros over hidden..G; R rides along so it lands exactly where serial shifts put it.
    always_comb begin
        w_vec = {r_man[MAN_W:0], r_g, r_r};
        w_lzc = EW'(MAN_W + 2);
        for (int i = 0; i < int'(MAN_W) + 2; i++) begin
            if (w_vec[i+1]) w_lzc = EW'(int'(MAN_W) + 1 - i);
        end
        w_lim = (r_exp > EW'(1)) ? r_exp - EW'(1) : '0;
        w_amt = (w_lzc < w_lim) ? w_lzc : w_lim;
        w_shl = w_vec << w_amt;
    end
`endif

    always_comb begin
        w_state_d   = r_state;
        w_sign_d    = r_sign;
        w_special_d = r_special;
        w_exp_d     = r_exp;
        w_man_d     = r_man;
        w_g_d       = r_g;
        w_r_d       = r_r;
        w_s_d       = r_s;
        w_result_d  = r_result;
        w_ovf_d     = r_ovf;
        w_unf_d     = r_unf;
        w_inx_d     = r_inx;
        case (r_state)
            StIdle: begin
                if (bus.inValid) begin
                    w_sign_d    = bus.sumSign;
                    w_special_d = bus.inSpecial;
                    w_exp_d     = {1'b0, bus.sumExponent};
                    w_man_d     = bus.sumMantissa;
                    w_g_d       = bus.guardBit;
                    w_r_d       = bus.roundBit;
                    w_s_d       = bus.stickyBit;
                    w_ovf_d     = 1'b0;
                    w_unf_d     = 1'b0;
                    w_inx_d     = 1'b0;
                    w_state_d   = StCheck;
                end
            end
            StCheck: begin
                if (r_special) begin
                    w_result_d = {r_sign, {EXP_W{1'b1}}, r_man[MAN_W-1:0]};
                    w_state_d  = StDone;
                end else if (r_man == '0 && !(r_g | r_r | r_s)) begin
                    w_result_d = {r_sign, {(EXP_W + MAN_W){1'b0}}};
                    w_state_d  = StDone;
                end else if (r_man[MW-1]) begin
                    w_man_d   = {1'b0, r_man[MW-1:1]};
                    w_exp_d   = r_exp + EW'(1);
                    w_g_d     = r_man[0];
                    w_r_d     = r_g;
                    w_s_d     = r_r | r_s;
                    w_state_d = StRound;
                end else if (r_man[MAN_W]) begin
                    w_state_d = StRound;
                end else begin
                    w_state_d = StShift;
                end
            end
            StShift: begin
`ifdef NORM_FAST_SHIFT_EN
                w_man_d = {1'b0, w_shl[MAN_W+2:2]};
                w_g_d   = w_shl[1];
                w_r_d   = w_shl[0];
                w_exp_d = r_exp - w_amt;
                if (w_shl[MAN_W+2]) begin
                    w_state_d = StRound;
                end else begin
                    w_unf_d    = 1'b1;
                    w_result_d = {r_sign, {(EXP_W + MAN_W){1'b0}}};
                    w_state_d  = StDone;
                end
`else
                if (r_man[MAN_W]) begin
                    w_state_d = StRound;
                end else if (r_exp <= EW'(1)) begin
                    w_unf_d    = 1'b1;
                    w_result_d = {r_sign, {(EXP_W + MAN_W){1'b0}}};
                    w_state_d  = StDone;
                end else begin
                    w_man_d = {1'b0, r_man[MAN_W-1:0], r_g};
                    w_g_d   = r_r;
                    w_r_d   = 1'b0;
                    w_exp_d = r_exp - EW'(1);
                    // Leave as soon as the bit reaching the hidden slot is set.
                    if (r_man[MAN_W-1]) w_state_d = StRound;
                end
`endif
            end
            StRound: begin
                w_man_d = w_rnd_man;
                w_exp_d = w_rnd_exp;
                w_inx_d = r_g | r_r | r_s;
                if (w_rnd_exp >= EXP_MAX) begin
                    w_ovf_d    = 1'b1;
                    w_result_d = {r_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                end else begin
                    w_result_d = {r_sign, w_rnd_exp[EXP_W-1:0], w_rnd_man[MAN_W-1:0]};
                end
                w_state_d = StDone;
            end
            StDone: begin
                if (bus.outReady) w_state_d = StIdle;
            end
            default: w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            r_state   <= StIdle;
            r_sign    <= 1'b0;
            r_special <= 1'b0;
            r_exp     <= '0;
            r_man     <= '0;
            r_g       <= 1'b0;
            r_r       <= 1'b0;
            r_s       <= 1'b0;
            r_result  <= '0;
            r_ovf     <= 1'b0;
            r_unf     <= 1'b0;
            r_inx     <= 1'b0;
        end else begin
            r_state   <= w_state_d;
            r_sign    <= w_sign_d;
            r_special <= w_special_d;
            r_exp     <= w_exp_d;
            r_man     <= w_man_d;
            r_g       <= w_g_d;
            r_r       <= w_r_d;
            r_s       <= w_s_d;
            r_result  <= w_result_d;
            r_ovf     <= w_ovf_d;
            r_unf     <= w_unf_d;
            r_inx     <= w_inx_d;
        end
    end

    assign bus.inReady   = (r_state == StIdle);
    assign bus.outValid  = (r_state == StDone);
    assign bus.result    = r_result;
    assign bus.overflow  = r_ovf;
    assign bus.underflow = r_unf;
    assign bus.inexact   = r_inx;
endmodule

// File: tb/tb_normalize_round.sv
// Directed bench for normalize_round with a result/flag scoreboard queue.
module tb_normalize_round;
    logic clock;
    logic resetN;

    typedef struct packed {
        logic [31:0] res;
        logic [2:0]  flg;  // {overflow, underflow, inexact}
    } exp_t;

    exp_t sb_q[$];
    int   checks;
    int   failures;

`ifdef NORM_FAST_SHIFT_EN
    localparam int LatCase2 = 4;
`else
    localparam int LatCase2 = 26;
`endif

    normalize_round_if #(.EXP_W(8), .MAN_W(23)) bus ();

    normalize_round #(.EXP_W(8), .MAN_W(23)) dut (
        .clock  (clock),
        .resetN (resetN),
        .bus    (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    // Call at a negedge; returns #1 after the accept edge.
    task automatic send(input logic sg, input logic [7:0] e, input logic [24:0] m,
                        input logic [2:0] grs, input logic sp,
                        input logic [31:0] er, input logic [2:0] ef);
        int n;
        n = 0;
        while (!bus.inReady && n < 100) begin
            @(negedge clock);
            n++;
        end
        chk("in_ready", 32'(bus.inReady), 32'd1);
        bus.sumSign     = sg;
        bus.sumExponent = e;
        bus.sumMantissa = m;
        bus.guardBit    = grs[2];
        bus.roundBit    = grs[1];
        bus.stickyBit   = grs[0];
        bus.inSpecial   = sp;
        bus.inValid     = 1'b1;
        sb_q.push_back('{res: er, flg: ef});
        @(posedge clock);
        #1 bus.inValid = 1'b0;
    endtask

    // Leaves the bench at the negedge where outValid was first seen.
    task automatic collect(input int lat);
        int   n;
        exp_t e;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!bus.outValid && n < 100);
        chk("out_valid", 32'(bus.outValid), 32'd1);
        if (lat > 0) chk("latency", 32'(n), 32'(lat));
        e = sb_q.pop_front();
        chk("result", bus.result, e.res);
        chk("flags", 32'({bus.overflow, bus.underflow, bus.inexact}), 32'(e.flg));
    endtask

    task automatic release_out();
        bus.outReady = 1'b1;
        @(posedge clock);
        #1 bus.outReady = 1'b0;
        @(negedge clock);
        chk("out_valid_drop", 32'(bus.outValid), 32'd0);
    endtask

    task automatic txn(input logic sg, input logic [7:0] e, input logic [24:0] m,
                       input logic [2:0] grs, input logic sp, input logic [31:0] er,
                       input logic [2:0] ef, input int lat);
        send(sg, e, m, grs, sp, er, ef);
        collect(lat);
        release_out();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        resetN          = 1'b0;
        bus.inValid     = 1'b0;
        bus.outReady    = 1'b0;
        bus.sumSign     = 1'b0;
        bus.sumExponent = '0;
        bus.sumMantissa = '0;
        bus.guardBit    = 1'b0;
        bus.roundBit    = 1'b0;
        bus.stickyBit   = 1'b0;
        bus.inSpecial   = 1'b0;
        #3;
        chk("rst_in_ready", 32'(bus.inReady), 32'd1);
        chk("rst_out_valid", 32'(bus.outValid), 32'd0);
        chk("rst_result", bus.result, 32'd0);
        chk("rst_flags", 32'({bus.overflow, bus.underflow, bus.inexact}), 32'd0);
        @(negedge clock);
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);

        // Carry normalize, one leading-zero normalize, long normalize
        txn(1'b0, 8'h7F, 25'h1000000, 3'b000, 1'b0, 32'h40000000, 3'b000, 3);
        txn(1'b0, 8'h7F, 25'h0400000, 3'b000, 1'b0, 32'h3F000000, 3'b000, 4);
        txn(1'b0, 8'h7F, 25'h0000001, 3'b000, 1'b0, 32'h34000000, 3'b000, LatCase2);
        // Rounding: tie-up to even, tie-stay even, odd tie, above half, sticky only
        txn(1'b0, 8'h7F, 25'h0FFFFFF, 3'b100, 1'b0, 32'h40000000, 3'b001, 3);
        txn(1'b0, 8'h7F, 25'h0800000, 3'b100, 1'b0, 32'h3F800000, 3'b001, 3);
        txn(1'b0, 8'h7F, 25'h0800001, 3'b100, 1'b0, 32'h3F800002, 3'b001, 3);
        txn(1'b0, 8'h7F, 25'h0800000, 3'b110, 1'b0, 32'h3F800001, 3'b001, 3);
        txn(1'b0, 8'h7F, 25'h0800000, 3'b001, 1'b0, 32'h3F800000, 3'b001, 3);
        txn(1'b0, 8'h7F, 25'h1000001, 3'b100, 1'b0, 32'h40000001, 3'b001, 3);
        // Overflow via carry and via rounding
        txn(1'b0, 8'hFE, 25'h1000000, 3'b000, 1'b0, 32'h7F800000, 3'b100, 3);
        txn(1'b1, 8'hFE, 25'h1000000, 3'b000, 1'b0, 32'hFF800000, 3'b100, 3);
        txn(1'b0, 8'hFE, 25'h0FFFFFF, 3'b100, 1'b0, 32'h7F800000, 3'b101, 3);
        // Zero, special pass-through, underflow
        txn(1'b1, 8'h55, 25'h0000000, 3'b000, 1'b0, 32'h80000000, 3'b000, 0);
        txn(1'b0, 8'hFF, 25'h0C00000, 3'b111, 1'b1, 32'h7FC00000, 3'b000, 0);
        txn(1'b1, 8'h10, 25'h0000001, 3'b000, 1'b0, 32'h80000000, 3'b010, 0);

        // Backpressure with an ignored inValid pulse
        send(1'b0, 8'h7F, 25'h1000000, 3'b000, 1'b0, 32'h40000000, 3'b000);
        collect(3);
        for (int i = 0; i < 10; i++) begin
            if (i == 4) begin
                bus.sumMantissa = 25'h0800000;
                bus.sumExponent = 8'h01;
                bus.inValid     = 1'b1;
            end
            if (i == 5) bus.inValid = 1'b0;
            @(negedge clock);
            chk("bp_out_valid", 32'(bus.outValid), 32'd1);
            chk("bp_result", bus.result, 32'h40000000);
            chk("bp_in_ready", 32'(bus.inReady), 32'd0);
        end
        release_out();
        chk("post_bp_in_ready", 32'(bus.inReady), 32'd1);

        // Asynchronous reset in the middle of a long normalize
        send(1'b0, 8'h7F, 25'h0000001, 3'b000, 1'b0, 32'h34000000, 3'b000);
        repeat (2) @(negedge clock);
        resetN = 1'b0;
        #1;
        chk("mid_rst_out_valid", 32'(bus.outValid), 32'd0);
        chk("mid_rst_in_ready", 32'(bus.inReady), 32'd1);
        chk("mid_rst_result", bus.result, 32'd0);
        sb_q.delete();
        @(negedge clock);
        resetN = 1'b1;
        @(negedge clock);
        txn(1'b0, 8'h7F, 25'h1000000, 3'b000, 1'b0, 32'h40000000, 3'b000, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
